// File: rtl/fifo_pkg.sv
// Shared sizing and word type for the FIFO queue and its register file.
package fifo_pkg;
  localparam int WIDTH = 4;
  localparam int DEPTH = 8;
  localparam int AW    = $clog2(DEPTH);

  typedef logic [WIDTH-1:0] word_t;
endpackage

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH register file: one synchronous write port, one asynchronous read port.
module fifo_mem
  import fifo_pkg::*;
(
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  word_t r_mem [DEPTH];

  // Storage is never reset; the pointers and counter alone define valid contents.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/fifo_queue.sv
// Synchronous FIFO: pointers, occupancy counter, flag decode and a registered read word.
module fifo_queue
  import fifo_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en_in,
  input  logic             en_out,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic             empty,
  output logic             full
);

  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic [WIDTH-1:0] r_out;

  logic             w_push_ok;
  logic             w_pop_ok;
  logic             w_we;
  logic [WIDTH-1:0] w_rdata;

  // Both requests are qualified against the pre-edge flags, so a pop at
  // count==0 cannot see the word being pushed in the same cycle.
  assign w_push_ok = en_in  && !full;
  assign w_pop_ok  = en_out && !empty;
  assign w_we      = w_push_ok && rst;

  assign empty = (r_count == '0);
  assign full  = (r_count == (AW+1)'(DEPTH));
  assign out   = r_out;

  fifo_mem u_mem (
    .clk   (clk),
    .we    (w_we),
    .waddr (r_wr_ptr),
    .wdata (in),
    .raddr (r_rd_ptr),
    .rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_out    <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_out    <= w_rdata;
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_queue.sv
// Directed bench for fifo_queue with hand-computed expectations and a queue model for the mixed run.
module tb_fifo_queue;
  logic       clk;
  logic       rst;
  logic       en_in;
  logic       en_out;
  logic [3:0] in;
  logic [3:0] out;
  logic       empty;
  logic       full;

  int n_checks;
  int n_errors;

  logic [3:0] q[$];
  logic [3:0] exp_out;
  logic       m_ei, m_eo, m_wok, m_pok;
  logic [3:0] m_d;
  logic [3:0] fill_vals [8];
  logic [3:0] popped;

  fifo_queue dut (
    .clk    (clk),
    .rst    (rst),
    .en_in  (en_in),
    .en_out (en_out),
    .in     (in),
    .out    (out),
    .empty  (empty),
    .full   (full)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Apply inputs for one edge; outputs are then sampled at the following negedge.
  task automatic cyc(input logic r, input logic ei, input logic eo, input logic [3:0] d);
    rst    = r;
    en_in  = ei;
    en_out = eo;
    in     = d;
    @(negedge clk);
  endtask

  // Model-driven cycle: qualifies against the model's pre-edge occupancy.
  task automatic mcyc(input logic ei, input logic eo, input logic [3:0] d);
    m_wok = ei && (q.size() < 8);
    m_pok = eo && (q.size() > 0);
    if (m_pok) exp_out = q.pop_front();
    if (m_wok) q.push_back(d);
    cyc(1'b1, ei, eo, d);
    check("mix_out",   {4'h0, out},   {4'h0, exp_out});
    check("mix_empty", {7'h0, empty}, {7'h0, (q.size() == 0)});
    check("mix_full",  {7'h0, full},  {7'h0, (q.size() == 8)});
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    fill_vals = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h8, 4'h9, 4'h2, 4'h7};

    // Reset held two cycles with a push request that must be ignored
    cyc(1'b0, 1'b1, 1'b0, 4'h9);
    cyc(1'b0, 1'b1, 1'b0, 4'h9);
    check("rst_empty", {7'h0, empty}, 8'h1);
    check("rst_full",  {7'h0, full},  8'h0);
    check("rst_out",   {4'h0, out},   8'h0);
    cyc(1'b1, 1'b0, 1'b0, 4'h0);
    check("rst_idle_empty", {7'h0, empty}, 8'h1);

    // Basic order
    cyc(1'b1, 1'b1, 1'b0, 4'h2);
    cyc(1'b1, 1'b1, 1'b0, 4'h3);
    cyc(1'b1, 1'b1, 1'b0, 4'h5);
    check("basic_nonempty", {7'h0, empty}, 8'h0);
    cyc(1'b1, 1'b0, 1'b1, 4'h0);
    check("basic_pop1", {4'h0, out}, 8'h2);
    cyc(1'b1, 1'b0, 1'b1, 4'h0);
    check("basic_pop2", {4'h0, out}, 8'h3);
    check("basic_left", {7'h0, empty}, 8'h0);
    cyc(1'b1, 1'b0, 1'b1, 4'h0);
    check("basic_pop3", {4'h0, out}, 8'h5);
    check("basic_drained", {7'h0, empty}, 8'h1);

    // Fill, overflow, drain
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b1, 1'b0, fill_vals[i]);
      if (i == 6) check("fill_not_full7", {7'h0, full}, 8'h0);
    end
    check("fill_full", {7'h0, full}, 8'h1);
    cyc(1'b1, 1'b1, 1'b0, 4'hF);
    check("ovf_full", {7'h0, full}, 8'h1);
    check("ovf_out_hold", {4'h0, out}, 8'h5);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b0, 1'b1, 4'h0);
      check("drain_out", {4'h0, out}, {4'h0, fill_vals[i]});
      if (i == 0) check("drain_full_clr", {7'h0, full}, 8'h0);
    end
    check("drain_empty", {7'h0, empty}, 8'h1);

    // Underflow
    cyc(1'b1, 1'b0, 1'b1, 4'h0);
    check("unf_out_hold", {4'h0, out}, 8'h7);
    check("unf_empty", {7'h0, empty}, 8'h1);
    cyc(1'b1, 1'b1, 1'b0, 4'hA);
    cyc(1'b1, 1'b0, 1'b1, 4'h0);
    check("unf_then_A", {4'h0, out}, 8'hA);
    check("unf_then_empty", {7'h0, empty}, 8'h1);

    // Simultaneous push/pop at count 3
    cyc(1'b1, 1'b1, 1'b0, 4'h1);
    cyc(1'b1, 1'b1, 1'b0, 4'h2);
    cyc(1'b1, 1'b1, 1'b0, 4'h3);
    cyc(1'b1, 1'b1, 1'b1, 4'h4);
    check("sim3_head", {4'h0, out}, 8'h1);
    check("sim3_empty", {7'h0, empty}, 8'h0);
    cyc(1'b1, 1'b0, 1'b1, 4'h0);
    check("sim3_pop2", {4'h0, out}, 8'h2);
    cyc(1'b1, 1'b0, 1'b1, 4'h0);
    check("sim3_pop3", {4'h0, out}, 8'h3);
    cyc(1'b1, 1'b0, 1'b1, 4'h0);
    check("sim3_tail", {4'h0, out}, 8'h4);
    check("sim3_empty_end", {7'h0, empty}, 8'h1);

    // Simultaneous at count 0: push only, no fall-through
    cyc(1'b1, 1'b1, 1'b1, 4'h6);
    check("sim0_out_hold", {4'h0, out}, 8'h4);
    check("sim0_pushed", {7'h0, empty}, 8'h0);
    cyc(1'b1, 1'b0, 1'b1, 4'h0);
    check("sim0_pop", {4'h0, out}, 8'h6);
    check("sim0_empty", {7'h0, empty}, 8'h1);

    // Simultaneous at count 8: pop only, write dropped
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, 1'b0, 4'(i + 1));
    check("sim8_full", {7'h0, full}, 8'h1);
    cyc(1'b1, 1'b1, 1'b1, 4'hD);
    check("sim8_head", {4'h0, out}, 8'h1);
    check("sim8_full_clr", {7'h0, full}, 8'h0);
    for (int i = 0; i < 7; i++) begin
      cyc(1'b1, 1'b0, 1'b1, 4'h0);
      check("sim8_drain", {4'h0, out}, {4'h0, 4'(i + 2)});
    end
    check("sim8_drop_empty", {7'h0, empty}, 8'h1);

    // Mixed run across pointer wrap against the queue model
    q.delete();
    exp_out = 4'h8;
    for (int i = 0; i < 20; i++) begin
      m_ei = (i % 4) != 3;
      m_eo = ((i % 3) == 0) || (i > 12);
      m_d  = 4'(i * 5 + 3);
      mcyc(m_ei, m_eo, m_d);
    end
    for (int i = 0; i < 16 && q.size() != 5; i++) begin
      if (q.size() < 5) mcyc(1'b1, 1'b0, 4'(i + 9));
      else              mcyc(1'b0, 1'b1, 4'h0);
    end
    check("mid_count5", 8'(q.size()), 8'd5);

    // Mid-run reset with entries stored
    cyc(1'b0, 1'b0, 1'b0, 4'h0);
    check("midrst_empty", {7'h0, empty}, 8'h1);
    check("midrst_full",  {7'h0, full},  8'h0);
    check("midrst_out",   {4'h0, out},   8'h0);
    cyc(1'b1, 1'b0, 1'b1, 4'h0);
    check("midrst_unf_out", {4'h0, out}, 8'h0);
    cyc(1'b1, 1'b1, 1'b0, 4'hB);
    cyc(1'b1, 1'b0, 1'b1, 4'h0);
    check("midrst_B", {4'h0, out}, 8'hB);
    check("midrst_B_empty", {7'h0, empty}, 8'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
